// File: rtl/iscas_bist_pkg.sv
// Shared types and constants for the ISCAS BIST controller.
// The same 8-bit shift function serves both the pattern LFSR and the MISR.
package iscas_bist_pkg;

    localparam int REG_W = 8;
    localparam logic [REG_W-1:0] TAP_MASK = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DONE
    } bist_state_e;

    // Fibonacci step: shift left, feed back the parity of the tapped bits, then fold in xin.
    function automatic logic [REG_W-1:0] shift_next(input logic [REG_W-1:0] q,
                                                    input logic [REG_W-1:0] mask,
                                                    input logic [REG_W-1:0] xin);
        return {q[REG_W-2:0], ^(q & mask)} ^ xin;
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 8-bit Fibonacci shift register with an XOR-in vector.
// With a zero XOR-in it acts as a pattern LFSR; with the CUT response folded in, it acts as a MISR.
module bist_lfsr
    import iscas_bist_pkg::*;
#(
    parameter logic [REG_W-1:0] MASK    = TAP_MASK,
    parameter logic [REG_W-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [REG_W-1:0] load_val_i,
    input  logic             en_i,
    input  logic [REG_W-1:0] xin_i,
    output logic [REG_W-1:0] q_o
);

    logic [REG_W-1:0] state_q;
    logic [REG_W-1:0] state_d;

    // A load takes priority so that a run can restart on the same edge it is requested.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (en_i) begin
            state_d = shift_next(state_q, MASK, xin_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RST_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign q_o = state_q;

endmodule

// File: rtl/iscas_bist_ctrl.sv
// BIST controller for an ISCAS benchmark: applies an initialising pattern, then N_PAT LFSR
// patterns to the CUT, compacting its responses into an 8-bit MISR signature checked against GOLDEN.
module iscas_bist_ctrl
    import iscas_bist_pkg::*;
#(
    parameter int               PI_W     = 4,
    parameter int               PO_W     = 1,
    parameter int               N_PAT    = 255,
    parameter int               INIT_CYC = 4,
    parameter logic [PI_W-1:0]  INIT_PAT = '0,
    parameter logic [REG_W-1:0] SEED     = 8'h01
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             START,
    input  logic [REG_W-1:0] GOLDEN,
    input  logic [PO_W-1:0]  RESP,
    output logic [PI_W-1:0]  PAT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [REG_W-1:0] SIG
);

    localparam logic [7:0] INIT_LAST = (INIT_CYC > 0) ? 8'(INIT_CYC - 1) : 8'd0;
    localparam logic [7:0] RUN_LAST  = 8'(N_PAT - 1);

    bist_state_e      state_q;
    bist_state_e      state_d;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;
    logic             pass_q;
    logic             pass_d;

    logic             launch;
    logic             advance;
    logic             last_run;
    logic [REG_W-1:0] lfsr_q;
    logic [REG_W-1:0] misr_q;
    logic [REG_W-1:0] misr_next;
    logic [REG_W-1:0] resp_ext;
    logic             unused_lfsr_bits;

    assign launch   = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign advance  = (state_q == ST_RUN);
    assign last_run = advance && (cnt_q == RUN_LAST);

    always_comb begin
        resp_ext             = '0;
        resp_ext[PO_W-1:0]   = RESP;
    end

    assign misr_next        = shift_next(misr_q, TAP_MASK, resp_ext);
    assign unused_lfsr_bits = ^lfsr_q;

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d = (INIT_CYC > 0) ? ST_INIT : ST_RUN;
                end
            end
            ST_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == RUN_LAST) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One counter times both phases; it restarts at every phase change so it never wraps.
    always_comb begin
        cnt_d  = '0;
        pass_d = pass_q;
        if ((state_q == ST_INIT || state_q == ST_RUN) && (state_d == state_q)) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (launch) begin
            pass_d = 1'b0;
        end else if (last_run) begin
            pass_d = (misr_next == GOLDEN);
        end
    end

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            cnt_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pass_q <= pass_d;
        end
    end

    always_comb begin
        PAT  = '0;
        BUSY = 1'b0;
        DONE = 1'b0;
        PASS = 1'b0;
        case (state_q)
            ST_INIT: begin
                PAT  = INIT_PAT;
                BUSY = 1'b1;
            end
            ST_RUN: begin
                PAT  = lfsr_q[PI_W-1:0];
                BUSY = 1'b1;
            end
            ST_DONE: begin
                DONE = 1'b1;
                PASS = pass_q;
            end
            default: ;
        endcase
    end

    bist_lfsr #(
        .MASK    (TAP_MASK),
        .RST_VAL (SEED)
    ) u_pat_lfsr (
        .clk_i      (CK),
        .rst_ni     (RSTN),
        .load_i     (launch),
        .load_val_i (SEED),
        .en_i       (advance),
        .xin_i      ('0),
        .q_o        (lfsr_q)
    );

    bist_lfsr #(
        .MASK    (TAP_MASK),
        .RST_VAL ('0)
    ) u_misr (
        .clk_i      (CK),
        .rst_ni     (RSTN),
        .load_i     (launch),
        .load_val_i ('0),
        .en_i       (advance),
        .xin_i      (resp_ext),
        .q_o        (misr_q)
    );

    assign SIG = misr_q;

endmodule
